// File: rtl/led_row_scanner.sv
// led_row_scanner: walks a ROWS x DATA_W row memory and drives a multiplexed
// LED matrix (one-hot row strobe + column lines) with fixed dwell and blanking.
// Optional macro LED_SCAN_BRIGHTNESS_EN adds a 4-bit bright input that
// PWM-gates the lit row during SHOW.
//
// State table
//   state   | meaning
//   IDLE    | scan off, outputs dark, waiting for enable
//   ADDR    | read address presented for the current row, outputs dark
//   LATCH   | address held one more cycle, pattern captured on exit
//   SHOW    | row lit for DWELL cycles
//   BLNK    | anti-ghosting dark gap of BLANK cycles
module led_row_scanner #(
  parameter int DATA_W = 10,
  parameter int ROWS   = 4,
  parameter int ADDR_W = 2,
  parameter int DWELL  = 1000,
  parameter int BLANK  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
`ifdef LED_SCAN_BRIGHTNESS_EN
  input  logic [3:0]        bright,
`endif
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr_rd,
  output logic [ROWS-1:0]   row_sel,
  output logic [DATA_W-1:0] col_out,
  output logic              frame_start
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL + 1) : 1;
  localparam int BL_W = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [BL_W-1:0]   BLANK_LAST = BL_W'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(ROWS - 1);
  localparam logic [ROWS-1:0]   ROW_ONE    = ROWS'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_SHOW  = 3'd3;
  localparam logic [2:0] S_BLNK  = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [ROWS-1:0]   r_row_sel;
  logic [DATA_W-1:0] r_col;
  logic              r_frame_start;
  logic [DW_W-1:0]   r_dwell;
  logic [BL_W-1:0]   r_blank;

  logic [ADDR_W-1:0] w_idx_next;
  logic [ROWS-1:0]   w_onehot;

`ifdef LED_SCAN_BRIGHTNESS_EN
  // Latched pattern is kept separately so PWM can blank the outputs without
  // losing the row contents.
  logic [DATA_W-1:0] r_pat;
  logic [ROWS-1:0]   r_onehot;
  logic [3:0]        r_pwm;
  logic [3:0]        w_pwm_inc;
  assign w_pwm_inc = r_pwm + 4'd1;
`endif

  assign w_idx_next = (r_idx == ROW_LAST) ? '0 : r_idx + ADDR_W'(1);
  assign w_onehot   = ROW_ONE << r_idx;

  assign mem_addr_rd = r_addr;
  assign row_sel     = r_row_sel;
  assign col_out     = r_col;
  assign frame_start = r_frame_start;

  // Scan sequencer: state, row index, timers and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_addr        <= '0;
      r_row_sel     <= '0;
      r_col         <= '0;
      r_frame_start <= 1'b0;
      r_dwell       <= '0;
      r_blank       <= '0;
`ifdef LED_SCAN_BRIGHTNESS_EN
      r_pat         <= '0;
      r_onehot      <= '0;
      r_pwm         <= '0;
`endif
    end else begin
      r_frame_start <= 1'b0;
      if (!enable) begin
        r_state   <= S_IDLE;
        r_idx     <= '0;
        r_addr    <= '0;
        r_row_sel <= '0;
        r_col     <= '0;
        r_dwell   <= '0;
        r_blank   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state       <= S_ADDR;
            r_idx         <= '0;
            r_addr        <= '0;
            r_frame_start <= 1'b1;
            r_row_sel     <= '0;
            r_col         <= '0;
          end
          S_ADDR: begin
            r_state <= S_LATCH;
          end
          S_LATCH: begin
            // Sampling a cycle after the address settles covers both
            // combinational and registered memory reads.
            r_state <= S_SHOW;
            r_dwell <= '0;
`ifdef LED_SCAN_BRIGHTNESS_EN
            r_pat    <= mem_data;
            r_onehot <= w_onehot;
            r_pwm    <= '0;
            if (bright != 4'd0) begin
              r_row_sel <= w_onehot;
              r_col     <= mem_data;
            end else begin
              r_row_sel <= '0;
              r_col     <= '0;
            end
`else
            r_row_sel <= w_onehot;
            r_col     <= mem_data;
`endif
          end
          S_SHOW: begin
            if (r_dwell == DWELL_LAST) begin
              r_row_sel <= '0;
              r_col     <= '0;
              if (BLANK > 0) begin
                r_state <= S_BLNK;
                r_blank <= '0;
              end else begin
                r_state       <= S_ADDR;
                r_idx         <= w_idx_next;
                r_addr        <= w_idx_next;
                r_frame_start <= (w_idx_next == '0);
              end
            end else begin
              r_dwell <= r_dwell + DW_W'(1);
`ifdef LED_SCAN_BRIGHTNESS_EN
              r_pwm <= w_pwm_inc;
              if (w_pwm_inc < bright) begin
                r_row_sel <= r_onehot;
                r_col     <= r_pat;
              end else begin
                r_row_sel <= '0;
                r_col     <= '0;
              end
`endif
            end
          end
          S_BLNK: begin
            if (r_blank == BLANK_LAST) begin
              r_state       <= S_ADDR;
              r_idx         <= w_idx_next;
              r_addr        <= w_idx_next;
              r_frame_start <= (w_idx_next == '0);
            end else begin
              r_blank <= r_blank + BL_W'(1);
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_addr    <= '0;
            r_row_sel <= '0;
            r_col     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_row_scanner.sv
// Self-checking bench for led_row_scanner (DWELL=4, BLANK=1, ROWS=4).
module tb_led_row_scanner;
  localparam int DATA_W = 10;
  localparam int ROWS   = 4;
  localparam int ADDR_W = 2;
  localparam int DWELL  = 4;
  localparam int BLANK  = 1;
  localparam int RP     = 2 + DWELL + BLANK;
  localparam int FP     = ROWS * RP;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_addr_rd;
  logic [ROWS-1:0]   row_sel;
  logic [DATA_W-1:0] col_out;
  logic              frame_start;
`ifdef LED_SCAN_BRIGHTNESS_EN
  logic [3:0]        bright = 4'hF;
`endif

  logic [DATA_W-1:0] tb_mem [ROWS];

  always #5 clk = ~clk;
  assign mem_data = tb_mem[mem_addr_rd];

  led_row_scanner #(
    .DATA_W(DATA_W), .ROWS(ROWS), .ADDR_W(ADDR_W), .DWELL(DWELL), .BLANK(BLANK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
`ifdef LED_SCAN_BRIGHTNESS_EN
    .bright(bright),
`endif
    .mem_data(mem_data),
    .mem_addr_rd(mem_addr_rd),
    .row_sel(row_sel),
    .col_out(col_out),
    .frame_start(frame_start)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_fs = -1;
  int fs_gap = 0;

  // Reference: scan position p counts edges since the frame-start edge.
  bit                m_active = 1'b0;
  int                m_p = 0;
  logic [DATA_W-1:0] m_snap = '0;

  typedef struct {
    logic              en;
    logic [ROWS-1:0]   rs;
    logic [DATA_W-1:0] col;
    logic              fs;
    logic [ADDR_W-1:0] addr;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    if (!enable) m_active = 1'b0;
    else if (!m_active) begin
      m_active = 1'b1;
      m_p = 0;
    end else begin
      m_p++;
      if (m_p % RP == 2) m_snap = tb_mem[(m_p / RP) % ROWS];
    end
  endtask

  task automatic step();
    int row, pos;
    bit lit;
    logic [ROWS-1:0]   e_rs;
    logic [DATA_W-1:0] e_col;
    logic              e_fs;
    logic [ADDR_W-1:0] e_addr;
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    e_rs = '0; e_col = '0; e_fs = 1'b0; e_addr = '0;
    if (m_active) begin
      row = (m_p / RP) % ROWS;
      pos = m_p % RP;
      lit = (pos >= 2) && (pos < 2 + DWELL);
`ifdef LED_SCAN_BRIGHTNESS_EN
      lit = lit && (((pos - 2) % 16) < int'(bright));
`endif
      e_addr = ADDR_W'(row);
      e_fs   = (m_p % FP == 0);
      if (lit) begin
        e_rs  = ROWS'(1) << row;
        e_col = m_snap;
      end
    end
    chk("model", {mem_addr_rd, row_sel, col_out, frame_start}, {e_addr, e_rs, e_col, e_fs});
    chk("invariant", ((row_sel == '0) ? (col_out == '0) : $onehot(row_sel)), 1);
    if (frame_start) begin
      if (last_fs >= 0) fs_gap = cyc - last_fs;
      last_fs = cyc;
    end
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (!(m_active && m_p == target) && n < 200) begin
      step();
      n++;
    end
    if (!(m_active && m_p == target)) begin
      total++;
      bad++;
      $display("FAIL run_to target=%0d not reached within 200 cycles", target);
    end
  endtask

  initial begin
    tb_mem[0] = 10'h002; tb_mem[1] = 10'h008; tb_mem[2] = 10'h020; tb_mem[3] = 10'h100;

    tbl[0]  = '{1'b0, 4'b0000, 10'h000, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 4'b0000, 10'h000, 1'b1, 2'd0};
    tbl[2]  = '{1'b1, 4'b0000, 10'h000, 1'b0, 2'd0};
    tbl[3]  = '{1'b1, 4'b0001, 10'h002, 1'b0, 2'd0};
    tbl[4]  = '{1'b1, 4'b0001, 10'h002, 1'b0, 2'd0};
    tbl[5]  = '{1'b1, 4'b0001, 10'h002, 1'b0, 2'd0};
    tbl[6]  = '{1'b1, 4'b0001, 10'h002, 1'b0, 2'd0};
    tbl[7]  = '{1'b1, 4'b0000, 10'h000, 1'b0, 2'd0};
    tbl[8]  = '{1'b1, 4'b0000, 10'h000, 1'b0, 2'd1};
    tbl[9]  = '{1'b1, 4'b0000, 10'h000, 1'b0, 2'd1};
    tbl[10] = '{1'b1, 4'b0010, 10'h008, 1'b0, 2'd1};

    #3;
    chk("reset_state", {mem_addr_rd, row_sel, col_out, frame_start}, 0);
    #9 rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      enable = tbl[i].en;
      step();
      chk("tbl_rs", row_sel, tbl[i].rs);
      chk("tbl_col", col_out, tbl[i].col);
      chk("tbl_fs", frame_start, tbl[i].fs);
      chk("tbl_addr", mem_addr_rd, tbl[i].addr);
    end

    // Write into row 1 while it is showing: takes effect next frame only.
    tb_mem[1] = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("show_hold_col", col_out, 10'h008);
    end
    run_to(FP + RP + 2);
    chk("next_frame_col", col_out, 10'h3FF);
    chk("next_frame_rs", row_sel, 4'b0010);
    chk("frame_gap", fs_gap, FP);

    // Drop enable during row 2 SHOW, then re-enable.
    run_to(FP + 2 * RP + 3);
    enable = 1'b0;
    step();
    chk("drop_rs", row_sel, 4'b0000);
    chk("drop_col", col_out, 10'h000);
    chk("drop_addr", mem_addr_rd, 2'd0);
    enable = 1'b1;
    step();
    chk("reen_fs", frame_start, 1'b1);
    chk("reen_addr", mem_addr_rd, 2'd0);

    // Asynchronous reset mid-SHOW, no clock edge in between.
    run_to(3);
    chk("pre_rst_rs", row_sel, 4'b0001);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("async_rst_rs", row_sel, 4'b0000);
    chk("async_rst_col", col_out, 10'h000);
    m_active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_after_rst", {row_sel, frame_start}, 0);
    end
    enable = 1'b1;
    step();
    chk("restart_fs", frame_start, 1'b1);

    // Randomized traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 7) == 0) tb_mem[$urandom_range(0, ROWS - 1)] = DATA_W'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
